// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - shared phase-datapath constants and adder-tree packing helper
package common_pkg;

   localparam int NL_OUT_PHASE_BITWIDTH = 8;
   localparam int NUM_SPINS             = 64;
   localparam int NUM_SPINS_EXP         = 6;

   // Bit offset of tree level k inside a flat bus that packs levels 0..k-1 back to back,
   // where level i holds n>>i elements of w+i bits each.
   function automatic int level_offset(input int n, input int w, input int k);
      int off;
      off = 0;
      for (int i = 0; i < k; i++) begin
         off += (n >> i) * (w + i);
      end
      return off;
   endfunction

endpackage

// File: rtl/adder_tree_level.sv
// rtl/adder_tree_level.sv - one registered pairwise-add level of the reduction tree
module adder_tree_level
   import common_pkg::*;
#(
   parameter int IN_W   = NL_OUT_PHASE_BITWIDTH,
   parameter int NUM_IN = NUM_SPINS
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              ena,
   input  logic [NUM_IN*IN_W-1:0]            in_data,
   output logic [(NUM_IN/2)*(IN_W+1)-1:0]    out_data
);

   localparam int OUT_W   = IN_W + 1;
   localparam int NUM_OUT = NUM_IN / 2;

   logic [NUM_OUT*OUT_W-1:0] sum_d;
   logic [NUM_OUT*OUT_W-1:0] sum_q;

   // Zero-extend both operands so the carry lands in the extra output bit.
   always_comb begin
      sum_d = '0;
      for (int j = 0; j < NUM_OUT; j++) begin
         sum_d[j*OUT_W +: OUT_W] = {1'b0, in_data[(2*j)*IN_W +: IN_W]}
                                 + {1'b0, in_data[(2*j+1)*IN_W +: IN_W]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sum_q <= '0;
      end else if (ena) begin
         sum_q <= sum_d;
      end
   end

   assign out_data = sum_q;

endmodule

// File: rtl/adder_64to1.sv
// rtl/adder_64to1.sv - pipelined unsigned 64-to-1 reduction adder, one tree level per stage
module adder_64to1
   import common_pkg::*;
#(
   parameter int NL_OUT_PHASE_BITWIDTH = common_pkg::NL_OUT_PHASE_BITWIDTH,
   parameter int NUM_SPINS             = common_pkg::NUM_SPINS,
   parameter int NUM_SPINS_EXP         = common_pkg::NUM_SPINS_EXP
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic                                       ena,
   input  logic [NL_OUT_PHASE_BITWIDTH-1:0]           input_matrix [NUM_SPINS-1:0],
   output logic [NL_OUT_PHASE_BITWIDTH+NUM_SPINS_EXP-1:0] sum
);

   localparam int W       = NL_OUT_PHASE_BITWIDTH;
   localparam int TREE_W  = level_offset(NUM_SPINS, W, NUM_SPINS_EXP + 1);
   localparam int SUM_OFF = level_offset(NUM_SPINS, W, NUM_SPINS_EXP);

   // Every tree level packed into one flat bus; level 0 is the raw input vector.
   logic [TREE_W-1:0] tree;

   for (genvar i = 0; i < NUM_SPINS; i++) begin : g_in
      assign tree[i*W +: W] = input_matrix[i];
   end

   for (genvar k = 1; k <= NUM_SPINS_EXP; k++) begin : g_lvl
      localparam int IN_W    = W + k - 1;
      localparam int NUM_IN  = NUM_SPINS >> (k - 1);
      localparam int IN_OFF  = level_offset(NUM_SPINS, W, k - 1);
      localparam int OUT_OFF = level_offset(NUM_SPINS, W, k);

      adder_tree_level #(
         .IN_W   (IN_W),
         .NUM_IN (NUM_IN)
      ) u_level (
         .clk      (clk),
         .reset    (reset),
         .ena      (ena),
         .in_data  (tree[IN_OFF +: NUM_IN*IN_W]),
         .out_data (tree[OUT_OFF +: (NUM_IN/2)*(IN_W+1)])
      );
   end

   assign sum = tree[SUM_OFF +: W + NUM_SPINS_EXP];

endmodule

// File: tb/tb_adder_64to1.sv
// tb/tb_adder_64to1.sv - directed self-checking bench for adder_64to1
module tb_adder_64to1;

   logic        clk;
   logic        reset;
   logic        ena;
   logic [7:0]  im [64];
   logic [13:0] sum;

   int checks;
   int failures;

   typedef struct {
      string       name;
      int          mode;   // 0 ramp, 1 constant, 2 alternating 0/val
      logic [7:0]  val;
      logic [13:0] exp;
   } vec_t;

   vec_t vecs [6];

   adder_64to1 dut (
      .clk          (clk),
      .reset        (reset),
      .ena          (ena),
      .input_matrix (im),
      .sum          (sum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [13:0] exp);
      checks++;
      if (sum !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", name, sum, exp);
      end
   endtask

   task automatic fill(input int mode, input logic [7:0] val);
      for (int i = 0; i < 64; i++) begin
         case (mode)
            0:       im[i] = 8'(i);
            1:       im[i] = val;
            default: im[i] = (i % 2 == 1) ? val : 8'd0;
         endcase
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      ena   = 1'b1;
      tick();
      reset = 1'b0;
      check("reset_state", 14'd0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      ena      = 1'b0;
      fill(1, 8'd0);

      vecs[0] = '{"ramp",        0, 8'd0,   14'd2016};
      vecs[1] = '{"full_scale",  1, 8'd255, 14'd16320};
      vecs[2] = '{"zero",        1, 8'd0,   14'd0};
      vecs[3] = '{"all_one",     1, 8'd1,   14'd64};
      vecs[4] = '{"all_0xaa",    1, 8'd170, 14'd10880};
      vecs[5] = '{"alt_0_255",   2, 8'd255, 14'd8160};

      tick();
      tick();

      // Single vectors held steady: zero through edge 5, result from edge 6 on.
      for (int t = 0; t < 6; t++) begin
         do_reset();
         fill(vecs[t].mode, vecs[t].val);
         for (int e = 1; e <= 8; e++) begin
            tick();
            if (e == 5) check({vecs[t].name, "_pre"}, 14'd0);
            if (e >= 6) check(vecs[t].name, vecs[t].exp);
         end
      end

      // Stream 1,2,3 back to back, then stall with 128 on the output.
      do_reset();
      fill(1, 8'd1); tick();
      fill(1, 8'd2); tick();
      fill(1, 8'd3);
      for (int e = 3; e <= 5; e++) tick();
      check("stream_pre", 14'd0);
      tick(); check("stream_e6", 14'd64);
      tick(); check("stream_e7", 14'd128);
      ena = 1'b0;
      fill(1, 8'd9);
      for (int s = 0; s < 3; s++) begin
         tick(); check("stream_stall_hold", 14'd128);
      end
      ena = 1'b1;
      fill(1, 8'd3);
      tick(); check("stream_e8_after_stall", 14'd192);

      // Ramp with a 3-cycle stall after edge 2: result on wall-clock edge 9.
      do_reset();
      fill(0, 8'd0);
      tick(); tick();
      ena = 1'b0;
      fill(1, 8'd200);
      for (int s = 0; s < 3; s++) begin
         tick(); check("ramp_stall_hold", 14'd0);
      end
      ena = 1'b1;
      fill(0, 8'd0);
      for (int e = 6; e <= 8; e++) tick();
      check("ramp_stall_e8", 14'd0);
      tick(); check("ramp_stall_e9", 14'd2016);

      // Stall with a full pipeline of ones while the input changes to twos.
      do_reset();
      fill(1, 8'd1);
      for (int e = 1; e <= 6; e++) tick();
      check("ones_full", 14'd64);
      fill(1, 8'd2);
      ena = 1'b0;
      for (int s = 0; s < 3; s++) tick();
      check("ones_stalled", 14'd64);
      ena = 1'b1;
      for (int e = 1; e <= 5; e++) tick();
      check("ones_drain", 14'd64);
      tick(); check("twos_arrive", 14'd128);

      // Reset mid-flight discards in-flight 255s.
      do_reset();
      fill(1, 8'd255);
      tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      fill(1, 8'd1);
      check("midflight_reset", 14'd0);
      for (int e = 1; e <= 5; e++) begin
         tick(); check("midflight_zero", 14'd0);
      end
      tick(); check("midflight_ones", 14'd64);
      tick(); check("midflight_ones_stable", 14'd64);

      // Reset wins over ena=0.
      fill(1, 8'd255);
      for (int e = 1; e <= 6; e++) tick();
      check("prefill_full", 14'd16320);
      reset = 1'b1;
      ena   = 1'b0;
      tick();
      check("reset_over_ena", 14'd0);
      reset = 1'b0;
      tick();
      check("reset_over_ena_hold", 14'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/adder_64to1.md
# adder_64to1

Pipelined, unsigned 64-to-1 reduction adder. Each accepted cycle, it sums all `NUM_SPINS` phase values from the nonlinearity output stage into one accumulated value. It sits downstream of the per-spin phase datapath and feeds the global sum consumers. Internally it is a balanced binary adder tree with one register per tree level, and it accepts one new vector per clock.

## Interface
Parameters (defaults are the shared package constants):
- `NL_OUT_PHASE_BITWIDTH`, 8: width of each unsigned input element.
- `NUM_SPINS`, 64: number of input elements; must equal 2**`NUM_SPINS_EXP`.
- `NUM_SPINS_EXP`, 6: log2 of `NUM_SPINS`; equals tree depth and pipeline latency.

Ports. One clock; reset is synchronous and active-high.
- `clk`  input  1: the single clock; all state updates on the rising edge.
- `reset`  input  1: synchronous, active-high; clears every pipeline register.
- `ena`  input  1: pipeline advance enable; when 0, all stages hold.
- `input_matrix`  input  `NL_OUT_PHASE_BITWIDTH` × [`NUM_SPINS`-1:0] (unpacked array): unsigned addends.
- `sum`  output  `NL_OUT_PHASE_BITWIDTH`+`NUM_SPINS_EXP`: registered unsigned total.

## Operation
- Tree level k (k = 1..`NUM_SPINS_EXP`) holds `NUM_SPINS`/2**k registers.
  - Each register is `NL_OUT_PHASE_BITWIDTH`+k bits wide and holds the sum of two adjacent level-(k-1) values.
  - Level 0 is `input_matrix`.
- Pairing: level k element j = level k-1 element 2j + level k-1 element 2j+1.
- All arithmetic is unsigned and zero-extended; widths grow one bit per level, so no overflow or saturation is possible.
  - Example: maximum result is 64×255 = 16320, which is below 2**14.
- `sum` is the single level-`NUM_SPINS_EXP` register, driven directly with no output logic.
- No valid or ready handshake. The consumer tracks latency using `ena`.

## Timing
- Latency: `NUM_SPINS_EXP` (6) enabled rising edges from the input sample to `sum` update.
- Throughput: one vector per enabled cycle. Back-to-back vectors emerge in order, one per enabled cycle.
- `ena`=0 on an edge: every level register holds. The next enabled edge resumes exactly where the pipeline stopped.
- `reset`=1 on an edge:
  - Every level register, and therefore `sum`, becomes 0 regardless of `ena`.
  - Reset has priority over `ena`.
- Reset mid-operation discards all in-flight partial sums.
  - After reset deasserts, `sum` stays 0 until 6 enabled edges have elapsed.
  - It then shows the sum of the vector sampled on the first enabled post-reset edge.
- Power-up before any reset: register contents are undefined. Users must reset before relying on `sum`.

## Structure
- Shared package `common_pkg` holds:
  - `NL_OUT_PHASE_BITWIDTH` (8)
  - `NUM_SPINS` (64)
  - `NUM_SPINS_EXP` (6)
- Module parameters default to these package constants.
- Natural sub-module: `adder_tree_level`.
  - Parameterised by input width and element count.
  - Registered pairwise adder with `clk`/`reset`/`ena`.
  - Instantiated `NUM_SPINS_EXP` times via generate, with width +1 per instance.
- Top-level `adder_64to1` is generate wiring only.

## Test plan
- Ramp: `input_matrix[i]`=i, `ena`=1, `reset`=0 after initial reset. `sum`=2016 (0x7E0) from the 6th edge on and stable thereafter.
- Full scale: all elements 255. `sum`=16320 (0x3FC0) after 6 edges; no wrap.
- Stream: vectors all-1, all-2, all-3 on consecutive edges. `sum` = 64, 128, 192 on edges 6, 7, 8.
- Stall: apply ramp, drop `ena` for 3 cycles after edge 2. `sum` = 2016 at enabled edge 6 (wall-clock edge 9) and holds its previous value while `ena`=0.
- Reset mid-flight: all elements 255, assert `reset` at edge 3, release, apply all-1.
  - `sum` stays 0 until 6 enabled edges after release.
  - `sum` then shows 64; 16320 never appears.
- Zero: all elements 0. `sum`=0 continuously after reset.
